keypad_bank: RTL and testbench

- Parametrised bank of key decoders driven by the PS/2 keyboard front end's make/breakk/key_code strobes.
- Replaces one fixed-code decoder instance per key with a single block holding NUM_KEYS codes.
- Adds per-key press/release edge pulses, a hold/auto-repeat generator and a most-recent-key index.
- Sits between the keyboard receiver and game control logic (flippers, launcher, menu).

---
 rtl/keypad_bank.sv | 141 ++++++++++++++
 tb/tb_keypad_bank.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_bank.sv
// rtl/keypad_bank.sv - bank of scan-code key decoders with edge pulses, auto-repeat and last-key index
module keypad_bank #(
  parameter int                    NUM_KEYS      = 7,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = {9'h07D, 9'h074, 9'h073, 9'h06B,
                                                    9'h072, 9'h069, 9'h070},
  parameter int                    HOLD_CYCLES   = 25000000,
  parameter int                    REPEAT_CYCLES = 5000000
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                make,
  input  logic                breakk,
  input  logic [8:0]          key_code,
  output logic [NUM_KEYS-1:0] keyIsPressed,
  output logic [NUM_KEYS-1:0] keyPressedPulse,
  output logic [NUM_KEYS-1:0] keyReleasedPulse,
  output logic [NUM_KEYS-1:0] keyRepeat,
  output logic                anyKeyPressed,
  output logic [3:0]          lastKeyIndex,
  output logic                lastKeyValid
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } key_state_e;

  key_state_e          state_q [NUM_KEYS];
  key_state_e          state_d [NUM_KEYS];
  logic [CW-1:0]       cnt_q   [NUM_KEYS];
  logic [CW-1:0]       cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] pressed_q, pressed_d;
  logic [NUM_KEYS-1:0] press_pulse_q, press_pulse_d;
  logic [NUM_KEYS-1:0] release_pulse_q, release_pulse_d;
  logic [NUM_KEYS-1:0] repeat_q, repeat_d;
  logic                any_q, any_d;
  logic [3:0]          last_idx_q, last_idx_d;
  logic                last_valid_q, last_valid_d;
  logic [NUM_KEYS-1:0] match;

  // Full 9-bit compare of the incoming code against every table entry
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (key_code == KEY_CODES[9*i +: 9]);
    end
  end

  // Per-key FSM next state; break beats make, release beats a coincident repeat tick
  always_comb begin
    press_pulse_d   = '0;
    release_pulse_d = '0;
    repeat_d        = '0;
    pressed_d       = '0;
    last_idx_d      = last_idx_q;
    last_valid_d    = last_valid_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (make && !breakk && match[i]) begin
            state_d[i]       = S_HOLD;
            cnt_d[i]         = '0;
            press_pulse_d[i] = 1'b1;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (breakk && match[i]) begin
            state_d[i]         = S_IDLE;
            cnt_d[i]           = '0;
            release_pulse_d[i] = 1'b1;
          end else if (cnt_q[i] == ((state_q[i] == S_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
            state_d[i]  = S_REPEAT;
            cnt_d[i]    = '0;
            repeat_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      pressed_d[i] = (state_d[i] != S_IDLE);
    end
    // Descending scan so the lowest newly pressed index wins
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press_pulse_d[i]) begin
        last_idx_d   = 4'(i);
        last_valid_d = 1'b1;
      end
    end
    any_d = |pressed_d;
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      pressed_q       <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      repeat_q        <= '0;
      any_q           <= 1'b0;
      last_idx_q      <= '0;
      last_valid_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      repeat_q        <= repeat_d;
      any_q           <= any_d;
      last_idx_q      <= last_idx_d;
      last_valid_q    <= last_valid_d;
    end
  end

  assign keyIsPressed     = pressed_q;
  assign keyPressedPulse  = press_pulse_q;
  assign keyReleasedPulse = release_pulse_q;
  assign keyRepeat        = repeat_q;
  assign anyKeyPressed    = any_q;
  assign lastKeyIndex     = last_idx_q;
  assign lastKeyValid     = last_valid_q;

endmodule

// File: tb/tb_keypad_bank.sv
// tb/tb_keypad_bank.sv - self-checking bench for keypad_bank against an age-based key model
module tb_keypad_bank;

  localparam int HOLD = 10;
  localparam int REP  = 4;

  logic       clk = 1'b0;
  logic       resetN;
  logic       make;
  logic       breakk;
  logic [8:0] key_code;
  logic [2:0] keyIsPressed, keyPressedPulse, keyReleasedPulse, keyRepeat;
  logic       anyKeyPressed;
  logic [3:0] lastKeyIndex;
  logic       lastKeyValid;

  keypad_bank #(
    .NUM_KEYS(3),
    .KEY_CODES({9'h072, 9'h069, 9'h070}),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .make(make),
    .breakk(breakk),
    .key_code(key_code),
    .keyIsPressed(keyIsPressed),
    .keyPressedPulse(keyPressedPulse),
    .keyReleasedPulse(keyReleasedPulse),
    .keyRepeat(keyRepeat),
    .anyKeyPressed(anyKeyPressed),
    .lastKeyIndex(lastKeyIndex),
    .lastKeyValid(lastKeyValid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [8:0] codes [3];
  bit         m_pressed [3];
  int         m_age [3];
  logic [2:0] e_level, e_ppulse, e_rpulse, e_rep;
  logic       e_any;
  logic [3:0] e_idx;
  logic       e_valid;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit fires(input int age);
    return (age >= HOLD) && (((age - HOLD) % REP) == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pressed[k] = 1'b0;
      m_age[k]     = 0;
    end
    e_level = '0; e_ppulse = '0; e_rpulse = '0; e_rep = '0;
    e_any = 1'b0; e_idx = '0; e_valid = 1'b0;
  endtask

  // Key model: age counts edges since the press; repeat ticks at HOLD, HOLD+REP, ...
  task automatic model_step(input logic m, input logic b, input logic [8:0] c);
    bit found;
    if (!resetN) begin
      model_reset();
      return;
    end
    e_ppulse = '0; e_rpulse = '0; e_rep = '0;
    for (int k = 0; k < 3; k++) begin
      if (m_pressed[k]) begin
        if (b && c == codes[k]) begin
          m_pressed[k] = 1'b0;
          m_age[k]     = 0;
          e_rpulse[k]  = 1'b1;
        end else begin
          m_age[k]++;
          if (fires(m_age[k])) e_rep[k] = 1'b1;
        end
      end else if (m && !b && c == codes[k]) begin
        m_pressed[k] = 1'b1;
        m_age[k]     = 0;
        e_ppulse[k]  = 1'b1;
      end
      e_level[k] = m_pressed[k];
    end
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (e_ppulse[k] && !found) begin
        e_idx   = 4'(k);
        e_valid = 1'b1;
        found   = 1'b1;
      end
    end
    e_any = |e_level;
  endtask

  task automatic cycle(input logic m, input logic b, input logic [8:0] c);
    make = m; breakk = b; key_code = c;
    @(posedge clk);
    model_step(m, b, c);
    @(negedge clk);
    #1;
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("keyIsPressed", 16'(keyIsPressed), 16'(e_level));
      check("keyPressedPulse", 16'(keyPressedPulse), 16'(e_ppulse));
      check("keyReleasedPulse", 16'(keyReleasedPulse), 16'(e_rpulse));
      check("keyRepeat", 16'(keyRepeat), 16'(e_rep));
      check("anyKeyPressed", 16'(anyKeyPressed), 16'(e_any));
      check("lastKeyIndex", 16'(lastKeyIndex), 16'(e_idx));
      check("lastKeyValid", 16'(lastKeyValid), 16'(e_valid));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, 16'(keyIsPressed), 16'h0);
    check({tag, "_ppulse"}, 16'(keyPressedPulse), 16'h0);
    check({tag, "_rpulse"}, 16'(keyReleasedPulse), 16'h0);
    check({tag, "_rep"}, 16'(keyRepeat), 16'h0);
    check({tag, "_any"}, 16'(anyKeyPressed), 16'h0);
    check({tag, "_idx"}, 16'(lastKeyIndex), 16'h0);
    check({tag, "_valid"}, 16'(lastKeyValid), 16'h0);
  endtask

  // Hold key 0 for 30 cycles (optionally resending make every 3), then release on a tick cycle
  task automatic hold_run(input bit typematic, input string tag);
    logic [30:0] got;
    int          extra_press;
    got = '0;
    extra_press = 0;
    cycle(1'b1, 1'b0, 9'h070);
    check({tag, "_press"}, 16'(keyPressedPulse), 16'h1);
    for (int n = 1; n <= 33; n++) begin
      cycle(typematic && (n % 3 == 0), 1'b0, 9'h070);
      if (n <= 30) got[n] = keyRepeat[0];
      if (keyPressedPulse[0]) extra_press++;
    end
    check({tag, "_repmask"}, 16'(got >> 10), 16'(31'h44444400 >> 10));
    check({tag, "_extra_press"}, 16'(extra_press), 16'h0);
    cycle(1'b0, 1'b1, 9'h070);
    check({tag, "_rel"}, 16'(keyReleasedPulse), 16'h1);
    check({tag, "_rel_rep"}, 16'(keyRepeat), 16'h0);
    check({tag, "_rel_level"}, 16'(keyIsPressed), 16'h0);
    check({tag, "_rel_idx"}, 16'(lastKeyIndex), 16'h0);
  endtask

  initial begin
    logic [8:0] c;
    codes[0] = 9'h070; codes[1] = 9'h069; codes[2] = 9'h072;
    model_reset();
    resetN = 1'b0; make = 1'b0; breakk = 1'b0; key_code = '0;
    repeat (3) @(negedge clk);
    #1;
    resetN = 1'b1;
    check_all_zero("reset");
    chk_en = 1'b1;

    cycle(1'b1, 1'b0, 9'h069);
    check("p1_level", 16'(keyIsPressed), 16'h2);
    check("p1_ppulse", 16'(keyPressedPulse), 16'h2);
    check("p1_idx", 16'(lastKeyIndex), 16'h1);
    check("p1_valid", 16'(lastKeyValid), 16'h1);
    check("p1_any", 16'(anyKeyPressed), 16'h1);
    cycle(1'b0, 1'b0, 9'h000);
    check("p1_pulse_gone", 16'(keyPressedPulse), 16'h0);
    cycle(1'b0, 1'b1, 9'h069);

    hold_run(1'b0, "hold");
    hold_run(1'b1, "typematic");

    cycle(1'b1, 1'b0, 9'h072);
    cycle(1'b1, 1'b0, 9'h069);
    check("multi_level", 16'(keyIsPressed), 16'h6);
    check("multi_idx", 16'(lastKeyIndex), 16'h1);
    cycle(1'b0, 1'b1, 9'h072);
    check("multi_rel2_level", 16'(keyIsPressed), 16'h2);
    check("multi_rel2_pulse", 16'(keyReleasedPulse), 16'h4);
    cycle(1'b1, 1'b1, 9'h069);
    check("both_level", 16'(keyIsPressed), 16'h0);
    check("both_rel", 16'(keyReleasedPulse), 16'h2);
    check("both_any", 16'(anyKeyPressed), 16'h0);
    cycle(1'b1, 1'b0, 9'h1F0);
    check("ext_level", 16'(keyIsPressed), 16'h0);
    check("ext_ppulse", 16'(keyPressedPulse), 16'h0);
    check("ext_idx", 16'(lastKeyIndex), 16'h1);

    cycle(1'b1, 1'b0, 9'h072);
    repeat (14) cycle(1'b0, 1'b0, 9'h000);
    check("pre_reset_level", 16'(keyIsPressed), 16'h4);
    resetN = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    #1;
    repeat (2) cycle(1'b0, 1'b0, 9'h000);
    resetN = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 9'h000);
    cycle(1'b0, 1'b1, 9'h072);
    check("post_reset_rel", 16'(keyReleasedPulse), 16'h0);

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 6) c = codes[r % 3];
      else if (r == 7) c = 9'h1F0;
      else c = 9'($urandom);
      if (n == 1500) begin
        resetN = 1'b0;
        #1;
        model_reset();
        check_all_zero("rand_reset");
        cycle(1'b0, 1'b0, 9'h000);
        resetN = 1'b1;
      end
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, c);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
